// File: rtl/guineveer_mbox_monitor.sv
// Mailbox console/status monitor: snoops NUM_CH write streams, buffers printable bytes per
// channel and drains them round-robin. Timeout detection is enabled by GUINEVEER_MBOX_TIMEOUT_EN.
module guineveer_mbox_monitor #(
    parameter int                NUM_CH     = 2,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter logic [ADDR_W-1:0] MBOX_ADDR  = ADDR_W'(32'h80f8_0000),
    parameter int                FIFO_DEPTH = 16,
    parameter int                CNT_W      = 32,
    parameter int                MAX_CYCLES = 99_000_000,
    localparam int               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        wr_valid_i,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wr_data_i,
    output logic                     char_valid_o,
    output logic [7:0]               char_data_o,
    output logic [CH_W-1:0]          char_ch_o,
    input  logic                     char_ready_i,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic                     done_o,
    output logic [NUM_CH-1:0]        overflow_o,
    output logic [CNT_W-1:0]         cycle_cnt_o
);
    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   WRAP_BIT  = {1'b1, {PTR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       CLS_NONE  = 2'd0;
    localparam logic [1:0]       CLS_PRINT = 2'd1;
    localparam logic [1:0]       CLS_PASS  = 2'd2;
    localparam logic [1:0]       CLS_FAIL  = 2'd3;

    logic [7:0]        mem_q [NUM_CH][FIFO_DEPTH];
    logic [7:0]        mem_d [NUM_CH][FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q [NUM_CH];
    logic [PTR_W:0]    wr_ptr_d [NUM_CH];
    logic [PTR_W:0]    rd_ptr_q [NUM_CH];
    logic [PTR_W:0]    rd_ptr_d [NUM_CH];
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [CH_W-1:0]   rr_q, rr_d, lock_ch_q, lock_ch_d;
    logic              lock_q, lock_d;
    logic              pass_pend_q, pass_pend_d;
    logic              pass_q, pass_d, fail_q, fail_d;
    logic              timeout_q, timeout_d, done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        byte_s [NUM_CH];
    logic [NUM_CH-1:0] push_s, pop_s, nonempty_s, full_s;
    logic              pass_req_s, fail_req_s, pass_acc_s, pass_fire_s;
    logic              valid_s, fire_s, all_empty_s, cnt_inc_s, timeout_hit_s;
    logic [CH_W-1:0]   sel_s;
    logic              unused_data_s;

    function automatic logic [1:0] classify(input logic [7:0] b);
        logic [1:0] cls;
        if (b == 8'hFF) begin
            cls = CLS_PASS;
        end else if (b == 8'h01) begin
            cls = CLS_FAIL;
        end else if ((b >= 8'h06) && (b <= 8'h7E)) begin
            cls = CLS_PRINT;
        end else begin
            cls = CLS_NONE;
        end
        return cls;
    endfunction

    // First non-empty channel at or after start, wrapping around.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] ne,
                                                input logic [CH_W-1:0]   start);
        logic [CH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(start) + k) % NUM_CH;
            if (!found && ne[idx[CH_W-1:0]]) begin
                pick  = CH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign unused_data_s = ^wr_data_i;

    // Decode mailbox hits; nothing is accepted once a terminal flag is up.
    always_comb begin
        push_s     = '0;
        pass_req_s = 1'b0;
        fail_req_s = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            byte_s[c] = wr_data_i[c*DATA_W +: 8];
            if (wr_valid_i[c] && (wr_addr_i[c*ADDR_W +: ADDR_W] == MBOX_ADDR) && !done_q) begin
                case (classify(byte_s[c]))
                    CLS_PRINT: push_s[c]  = 1'b1;
                    CLS_PASS:  pass_req_s = 1'b1;
                    CLS_FAIL:  fail_req_s = 1'b1;
                    default:   push_s[c]  = 1'b0;
                endcase
            end else begin
                push_s[c] = 1'b0;
            end
        end
    end

    // Occupancy and output selection; a stalled byte keeps its channel until accepted.
    always_comb begin
        nonempty_s = '0;
        full_s     = '0;
        pop_s      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nonempty_s[c] = (wr_ptr_q[c] != rd_ptr_q[c]);
            full_s[c]     = (wr_ptr_q[c] == (rd_ptr_q[c] ^ WRAP_BIT));
        end
        valid_s = |nonempty_s;
        if (lock_q) begin
            sel_s = lock_ch_q;
        end else begin
            sel_s = rr_pick(nonempty_s, rr_q);
        end
        fire_s = valid_s && char_ready_i;
        for (int c = 0; c < NUM_CH; c++) begin
            pop_s[c] = fire_s && (sel_s == CH_W'(c));
        end
    end

    // FIFO update; a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_s[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
            end else begin
                rd_ptr_d[c] = rd_ptr_q[c];
            end
            if (push_s[c] && (!full_s[c] || pop_s[c])) begin
                mem_d[c][wr_ptr_q[c][PTR_W-1:0]] = byte_s[c];
                wr_ptr_d[c] = wr_ptr_q[c] + PTR_ONE;
            end else if (push_s[c]) begin
                overflow_d[c] = 1'b1;
            end else begin
                wr_ptr_d[c] = wr_ptr_q[c];
            end
        end
    end

    // Arbiter pointer advances past each granted channel; lock holds a stalled grant.
    always_comb begin
        if (fire_s) begin
            rr_d = (sel_s == CH_W'(NUM_CH - 1)) ? '0 : sel_s + CH_W'(1);
        end else begin
            rr_d = rr_q;
        end
        lock_d    = valid_s && !char_ready_i;
        lock_ch_d = sel_s;
    end

    assign cnt_inc_s = !done_q && (cnt_q != {CNT_W{1'b1}});

`ifdef GUINEVEER_MBOX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
    assign timeout_hit_s = cnt_inc_s && ((cnt_q + CNT_ONE) == MAX_C);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Terminal flags: fail beats pass, and pass waits until every FIFO has drained.
    always_comb begin
        all_empty_s = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            all_empty_s = all_empty_s && (wr_ptr_d[c] == rd_ptr_d[c]);
        end
        pass_acc_s  = pass_req_s && !fail_req_s;
        pass_fire_s = (pass_pend_q || pass_acc_s) && !fail_req_s && !timeout_hit_s &&
                      !done_q && all_empty_s;
        cnt_d       = cnt_inc_s ? (cnt_q + CNT_ONE) : cnt_q;
        fail_d      = fail_q || fail_req_s;
        pass_d      = pass_q || pass_fire_s;
        timeout_d   = timeout_q || timeout_hit_s;
        done_d      = pass_d || fail_d || timeout_d;
        if (fail_req_s || pass_fire_s || done_q) begin
            pass_pend_d = 1'b0;
        end else if (pass_acc_s) begin
            pass_pend_d = 1'b1;
        end else begin
            pass_pend_d = pass_pend_q;
        end
    end

    // Control state; reset discards buffered bytes and every flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            overflow_q  <= '0;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            pass_pend_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            pass_pend_q <= pass_pend_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    // Byte storage: a slot is only read after it has been written, so it carries no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign char_valid_o = valid_s;
    assign char_data_o  = valid_s ? mem_q[sel_s][rd_ptr_q[sel_s][PTR_W-1:0]] : 8'h00;
    assign char_ch_o    = valid_s ? sel_s : '0;
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign timeout_o    = timeout_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
    assign cycle_cnt_o  = cnt_q;

endmodule

// File: tb/tb_guineveer_mbox_monitor.sv
// Directed bench for guineveer_mbox_monitor (2 channels, 16-deep FIFOs); a second instance
// with a 7-bit counter and MAX_CYCLES=100 covers timeout and counter saturation.
module tb_guineveer_mbox_monitor;
    localparam logic [31:0] MBOX = 32'h80f8_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, ready;
    logic [1:0]   wr_valid;
    logic [63:0]  wr_addr;
    logic [127:0] wr_data;
    logic         char_valid, char_ch, pass, fail, tmo, done;
    logic [7:0]   char_data;
    logic [1:0]   ovf;
    logic [31:0]  cnt;

    logic         t_rst;
    logic [1:0]   t_valid;
    logic [63:0]  t_addr;
    logic [127:0] t_data;
    logic         t_cvalid, t_ch, t_pass, t_fail, t_tmo, t_done;
    logic [7:0]   t_cdata;
    logic [1:0]   t_ovf;
    logic [6:0]   t_cnt;

    int checks = 0;
    int errors = 0;
    int tcount = 0;

    guineveer_mbox_monitor dut (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .char_valid_o(char_valid), .char_data_o(char_data),
        .char_ch_o(char_ch), .char_ready_i(ready), .pass_o(pass), .fail_o(fail),
        .timeout_o(tmo), .done_o(done), .overflow_o(ovf), .cycle_cnt_o(cnt)
    );

    guineveer_mbox_monitor #(.CNT_W(7), .MAX_CYCLES(100)) dut_t (
        .clk_i(clk), .rst_i(t_rst), .wr_valid_i(t_valid), .wr_addr_i(t_addr),
        .wr_data_i(t_data), .char_valid_o(t_cvalid), .char_data_o(t_cdata),
        .char_ch_o(t_ch), .char_ready_i(1'b1), .pass_o(t_pass), .fail_o(t_fail),
        .timeout_o(t_tmo), .done_o(t_done), .overflow_o(t_ovf), .cycle_cnt_o(t_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
    endtask

    task automatic set_wr(input int ch, input logic [31:0] addr, input logic [7:0] b);
        wr_valid[ch]          = 1'b1;
        wr_addr[ch*32 +: 32]  = addr;
        wr_data[ch*64 +: 64]  = {56'hA5A5A5A5A5A5A5, b};
    endtask

    task automatic clr_wr();
        wr_valid = 2'b00;
        wr_addr  = 64'h0;
        wr_data  = 128'h0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ready = 1'b0;
        clr_wr();
        tick();
        tick();
        rst    = 1'b0;
        tcount = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({char_valid, char_data, pass, fail, tmo, done, ovf} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {char_valid, char_data, pass, fail, tmo, done, ovf});
        end
        checks++;
        if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
        tick();
        checks++;
        if (cnt !== 32'd1) begin errors++; $display("FAIL cnt_first got %0d exp 1", cnt); end
    endtask

    task automatic test_hello();
        logic [7:0] hello [3];
        hello = '{8'h48, 8'h69, 8'h0A};
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_wr(0, MBOX, hello[i]);
            if (i == 0) begin
                #1;
                checks++;
                if (char_valid !== 1'b0) begin errors++; $display("FAIL hello_nocomb got %b exp 0", char_valid); end
            end
            tick();
            checks++;
            if ({char_valid, char_ch, char_data} !== {1'b1, 1'b0, hello[i]}) begin
                errors++;
                $display("FAIL hello_b%0d got v%b ch%b %h exp v1 ch0 %h", i, char_valid, char_ch, char_data, hello[i]);
            end
        end
        clr_wr();
        tick();
        checks++;
        if (char_valid !== 1'b0) begin errors++; $display("FAIL hello_empty got %b exp 0", char_valid); end
    endtask

    task automatic test_interleave();
        logic [7:0] exp_d [6];
        logic       exp_c [6];
        exp_d = '{8'h61, 8'h78, 8'h62, 8'h79, 8'h63, 8'h7A};
        exp_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_wr(0, MBOX, exp_d[2*i]);
            set_wr(1, MBOX, exp_d[2*i+1]);
            tick();
        end
        clr_wr();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({char_valid, char_ch, char_data} !== {1'b1, 1'b0, 8'h61}) begin
                errors++;
                $display("FAIL stall_hold%0d got v%b ch%b %h exp v1 ch0 61", k, char_valid, char_ch, char_data);
            end
            tick();
        end
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({char_valid, char_ch, char_data} !== {1'b1, exp_c[i], exp_d[i]}) begin
                errors++;
                $display("FAIL rr_b%0d got v%b ch%b %h exp v1 ch%b %h", i, char_valid, char_ch, char_data, exp_c[i], exp_d[i]);
            end
            tick();
        end
        checks++;
        if (char_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got %b exp 0", char_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_wr(1, MBOX, 8'h20 + 8'(i));
            tick();
            if (i == 15) begin
                checks++;
                if (ovf !== 2'b00) begin errors++; $display("FAIL ovf_at16 got %b exp 00", ovf); end
            end
        end
        clr_wr();
        checks++;
        if (ovf !== 2'b10) begin errors++; $display("FAIL ovf_set got %b exp 10", ovf); end
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({char_valid, char_ch, char_data} !== {1'b1, 1'b1, 8'h20 + 8'(i)}) begin
                errors++;
                $display("FAIL ovf_drain%0d got v%b ch%b %h exp v1 ch1 %h", i, char_valid, char_ch, char_data, 8'h20 + 8'(i));
            end
            tick();
        end
        checks++;
        if ({char_valid, ovf} !== 3'b010) begin errors++; $display("FAIL ovf_after got %b exp 010", {char_valid, ovf}); end
        ready = 1'b0;
        set_wr(0, MBOX, 8'h41);
        tick();
        clr_wr();
        do_reset();
        checks++;
        if ({char_valid, ovf} !== 3'b000) begin errors++; $display("FAIL midreset got %b exp 000", {char_valid, ovf}); end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_wr(0, MBOX, 8'h30 + 8'(i));
            tick();
        end
        ready = 1'b1;
        set_wr(0, MBOX, 8'h50);
        tick();
        clr_wr();
        for (int i = 1; i < 17; i++) begin
            checks++;
            if (char_data !== ((i == 16) ? 8'h50 : 8'h30 + 8'(i))) begin
                errors++;
                $display("FAIL fullpp_b%0d got %h exp %h", i, char_data, (i == 16) ? 8'h50 : 8'h30 + 8'(i));
            end
            tick();
        end
        checks++;
        if ({char_valid, ovf} !== 3'b000) begin errors++; $display("FAIL fullpp_end got %b exp 000", {char_valid, ovf}); end
    endtask

    task automatic test_pass_drain();
        int frozen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_wr(0, MBOX, 8'h41 + 8'(i));
            tick();
        end
        set_wr(0, MBOX, 8'hFF);
        tick();
        clr_wr();
        tick();
        tick();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({pass, done, char_data} !== {2'b00, 8'h41 + 8'(i)}) begin
                errors++;
                $display("FAIL pass_wait%0d got p%b d%b %h exp p0 d0 %h", i, pass, done, char_data, 8'h41 + 8'(i));
            end
            tick();
        end
        checks++;
        if ({pass, fail, done} !== 3'b101) begin errors++; $display("FAIL pass_set got %b exp 101", {pass, fail, done}); end
        frozen = tcount;
        checks++;
        if (cnt !== 32'(frozen)) begin errors++; $display("FAIL cnt_at_done got %0d exp %0d", cnt, frozen); end
        set_wr(1, MBOX, 8'h01);
        tick();
        set_wr(1, MBOX, 8'h41);
        tick();
        clr_wr();
        tick();
        checks++;
        if ({char_valid, fail} !== 2'b00) begin errors++; $display("FAIL after_done got %b exp 00", {char_valid, fail}); end
        checks++;
        if (cnt !== 32'(frozen)) begin errors++; $display("FAIL cnt_frozen got %0d exp %0d", cnt, frozen); end
    endtask

    task automatic test_fail_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_wr(0, MBOX, 8'h41 + 8'(i));
            tick();
        end
        set_wr(0, MBOX, 8'hFF);
        tick();
        clr_wr();
        ready = 1'b1;
        set_wr(1, MBOX, 8'h01);
        tick();
        clr_wr();
        checks++;
        if ({pass, fail, done} !== 3'b011) begin errors++; $display("FAIL fail_set got %b exp 011", {pass, fail, done}); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if ({char_valid, char_data} !== {1'b1, 8'h41 + 8'(i)}) begin
                errors++;
                $display("FAIL fail_drain%0d got v%b %h exp v1 %h", i, char_valid, char_data, 8'h41 + 8'(i));
            end
            tick();
        end
        tick();
        checks++;
        if ({char_valid, pass} !== 2'b00) begin errors++; $display("FAIL fail_nopass got %b exp 00", {char_valid, pass}); end
    endtask

    task automatic test_fail_wins_and_immediate();
        do_reset();
        set_wr(0, MBOX, 8'hFF);
        set_wr(1, MBOX, 8'h01);
        tick();
        clr_wr();
        checks++;
        if ({pass, fail, done} !== 3'b011) begin errors++; $display("FAIL fail_wins got %b exp 011", {pass, fail, done}); end
        do_reset();
        set_wr(1, MBOX, 8'hFF);
        tick();
        clr_wr();
        checks++;
        if ({pass, fail, done} !== 3'b101) begin errors++; $display("FAIL pass_immediate got %b exp 101", {pass, fail, done}); end
    endtask

    task automatic test_ignored();
        logic [31:0] av [6];
        logic [7:0]  bv [6];
        av = '{MBOX + 32'd4, MBOX, MBOX, MBOX, MBOX, MBOX ^ 32'h0000_0001};
        bv = '{8'h41, 8'h05, 8'h7F, 8'h00, 8'h02, 8'hFF};
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_wr(0, av[i], bv[i]);
            tick();
            clr_wr();
            checks++;
            if ({char_valid, pass, fail, done, ovf} !== 6'b0) begin
                errors++;
                $display("FAIL ignore%0d got %b exp 000000", i, {char_valid, pass, fail, done, ovf});
            end
        end
        wr_addr[31:0] = MBOX;
        wr_data[7:0]  = 8'h41;
        tick();
        clr_wr();
        checks++;
        if (char_valid !== 1'b0) begin errors++; $display("FAIL ignore_novalid got %b exp 0", char_valid); end
        set_wr(0, MBOX, 8'h06);
        tick();
        checks++;
        if ({char_valid, char_data} !== {1'b1, 8'h06}) begin errors++; $display("FAIL edge_06 got %h exp 106", {char_valid, char_data}); end
        set_wr(0, MBOX, 8'h7E);
        tick();
        clr_wr();
        checks++;
        if ({char_valid, char_data} !== {1'b1, 8'h7E}) begin errors++; $display("FAIL edge_7e got %h exp 17e", {char_valid, char_data}); end
    endtask

    task automatic test_timeout();
        t_rst = 1'b1;
        tick();
        t_rst = 1'b0;
        repeat (99) tick();
        checks++;
        if ({t_cnt, t_tmo, t_done} !== {7'd99, 2'b00}) begin
            errors++;
            $display("FAIL tmo_99 got cnt %0d t%b d%b exp 99 0 0", t_cnt, t_tmo, t_done);
        end
        tick();
`ifdef GUINEVEER_MBOX_TIMEOUT_EN
        checks++;
        if ({t_cnt, t_tmo, t_done} !== {7'd100, 2'b11}) begin
            errors++;
            $display("FAIL tmo_100 got cnt %0d t%b d%b exp 100 1 1", t_cnt, t_tmo, t_done);
        end
        t_valid = 2'b01;
        t_addr  = {32'h0, MBOX};
        t_data  = {120'h0, 8'hFF};
        tick();
        t_valid = 2'b00;
        tick();
        checks++;
        if ({t_cnt, t_pass, t_fail} !== {7'd100, 2'b00}) begin
            errors++;
            $display("FAIL tmo_after got cnt %0d p%b f%b exp 100 0 0", t_cnt, t_pass, t_fail);
        end
`else
        checks++;
        if ({t_cnt, t_tmo, t_done} !== {7'd100, 2'b00}) begin
            errors++;
            $display("FAIL notmo_100 got cnt %0d t%b d%b exp 100 0 0", t_cnt, t_tmo, t_done);
        end
        repeat (30) tick();
        checks++;
        if ({t_cnt, t_tmo, t_done} !== {7'd127, 2'b00}) begin
            errors++;
            $display("FAIL cnt_sat got cnt %0d t%b d%b exp 127 0 0", t_cnt, t_tmo, t_done);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        ready   = 1'b0;
        t_rst   = 1'b1;
        t_valid = 2'b00;
        t_addr  = 64'h0;
        t_data  = 128'h0;
        clr_wr();
        test_reset();
        test_hello();
        test_interleave();
        test_overflow();
        test_full_pushpop();
        test_pass_drain();
        test_fail_drain();
        test_fail_wins_and_immediate();
        test_ignored();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/guineveer_mbox_monitor.md
# guineveer_mbox_monitor

Synthesizable multi-channel successor to the testbench mailbox console/status monitor. It snoops NUM_CH AXI write streams (one per hart/master) for writes to a mailbox address and buffers printable bytes per channel in FIFOs. Buffered bytes are drained through one round-robin valid/ready byte stream. It reports pass, fail and timeout as sticky flags. It sits beside the interconnect in simulation and FPGA-emulation tops, replacing ad-hoc `$write` monitors.

## Interface
Parameters:
- NUM_CH, 2, number of snooped write streams (1..8)
- ADDR_W, 32, write address width
- DATA_W, 64, write data width; only bits [7:0] are interpreted
- MBOX_ADDR, 32'h80f8_0000, mailbox address (exact match on all ADDR_W bits)
- FIFO_DEPTH, 16, bytes per channel FIFO; power of two, ≥2
- CNT_W, 32, cycle counter width
- MAX_CYCLES, 99_000_000, timeout threshold

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- wr_valid_i  in  NUM_CH  per-channel write beat valid (awvalid qualified by master)
- wr_addr_i  in  NUM_CH*ADDR_W  per-channel write address, channel c at [c*ADDR_W +: ADDR_W]
- wr_data_i  in  NUM_CH*DATA_W  per-channel write data
- char_valid_o  out  1  output byte valid
- char_data_o  out  8  output byte
- char_ch_o  out  max(1,$clog2(NUM_CH))  source channel of output byte
- char_ready_i  in  1  consumer accepts byte
- pass_o  out  1  sticky pass
- fail_o  out  1  sticky fail
- timeout_o  out  1  sticky timeout
- done_o  out  1  sticky, pass_o|fail_o|timeout_o
- overflow_o  out  NUM_CH  sticky per-channel byte-drop flag
- cycle_cnt_o  out  CNT_W  cycles since reset release, saturating

## Operation
- Hit on channel c: wr_valid_i[c] && wr_addr_i[c]==MBOX_ADDR. Byte b = data[7:0].
- b==8'hFF: pass request. b==8'h01: fail request. 8'h06≤b≤8'h7E: push to FIFO c. All other values are ignored.
- Once done_o=1, all hits are ignored. FIFOs continue to drain.
- FIFO c full on a push: byte dropped and overflow_o[c] set. Existing contents are untouched.
- Fail request: fail_o set the next cycle, without waiting for drain. Fail and pass in the same cycle on any channels: fail wins, pass is discarded.
- Pass request: latched as pending. pass_o is set in the first cycle after all FIFOs are empty, with no fail or timeout in between. A fail arriving while pass is pending cancels the pass.
- Output arbiter: round-robin over non-empty FIFOs, starting after the last granted channel (channel 0 first after reset). Selection is locked while char_valid_o && !char_ready_i. char_data_o and char_ch_o are held stable until the handshake.
- Pop happens only on char_valid_o && char_ready_i. Push and pop on the same FIFO in the same cycle are both honoured, including when the FIFO is full: the pop frees the slot and the push is accepted.
- cycle_cnt_o increments every cycle while !done_o and saturates at all ones.
- Reset values: all outputs 0, FIFOs empty, arbiter pointer at channel 0, pending pass cleared. Reset mid-operation discards buffered bytes and all flags.

## Timing
- Push at cycle N: byte can appear on char_valid_o at N+1 at earliest (registered FIFO read side, no input-to-output combinational path).
- char_valid_o does not depend combinationally on char_ready_i.
- Sustained throughput: 1 byte/cycle across all channels.
- fail_o: N+1 after fail hit. pass_o: N+1 if all FIFOs are empty at N. Otherwise it asserts the cycle after the final pop handshake.
- timeout_o: set in the cycle cycle_cnt_o transitions to MAX_CYCLES.
- done_o rises in the same cycle as the flag that causes it.

## Configuration
- GUINEVEER_MBOX_TIMEOUT_EN defined: timeout logic active as described. timeout_o sets done_o, and subsequent pass/fail requests are ignored.
- Not defined: timeout_o is constant 0 and no comparator is synthesized. cycle_cnt_o still counts, saturates, and freezes on done_o.

## Test plan
- Ch0 writes "Hi\n" to MBOX_ADDR with char_ready_i=1 → bytes 0x48,0x69,0x0A on char_data_o, char_ch_o=0, the first at N+1.
- Ch0 and ch1 each write 3 bytes in the same cycles → output alternates ch0,ch1,ch0,ch1,…; with char_ready_i=0 held 5 cycles, data stays stable.
- char_ready_i=0 and 18 bytes to ch1 with FIFO_DEPTH=16 → 16 buffered, overflow_o[1]=1, exactly the first 16 bytes emitted after ready.
- 4 bytes queued then 0xFF on ch0 with char_ready_i=0 → pass_o=0 until the 4th pop, then pass_o=done_o=1 the next cycle. Same setup with 0x01 on ch1 during drain → fail_o=1, pass_o never set.
- Write to MBOX_ADDR+4 or byte 0x05/0x7F → no output, no flags.
- MAX_CYCLES=100 with timeout macro defined and no writes → timeout_o=done_o=1 when cycle_cnt_o=100, later 0xFF ignored. Without the macro → timeout_o=0 throughout.
